rx_frame_deserializer: RTL and testbench
========================================

RX_FRAME_DESERIALIZER -- requirements
Module: rx_frame_deserializer

Interface
REQ-001 Parameter MAX_WIDTH, default 9: maximum data bits per frame, legal 5..16.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first received data bit is bit 0; 0 = first received bit is bit (len-1).
REQ-003 Port CLK  input  1  single clock, all state on rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-low reset.
REQ-005 Port sampled_data  input  1  bit value from data sampler.
REQ-006 Port sampled  input  1  one-cycle strobe, sampled_data valid this cycle.
REQ-007 Port deser_en  input  1  block enable; low aborts any frame.
REQ-008 Port frame_start  input  1  one-cycle pulse, start bit validated.
REQ-009 Port data_len  input  $clog2(MAX_WIDTH+1)  data bits per frame.
REQ-010 Port par_en  input  1  parity bit present.
REQ-011 Port par_type  input  1  0 = even, 1 = odd.
REQ-012 Port P_Data  output  MAX_WIDTH  received word, right-justified.
REQ-013 Port data_valid  output  1  one-cycle pulse, P_Data updated with good frame.
REQ-014 Port par_err  output  1  one-cycle pulse, parity mismatch.
REQ-015 Port frame_err  output  1  one-cycle pulse, stop bit sampled 0.
REQ-016 Port busy  output  1  high in any state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-018 IDLE -> DATA on frame_start & deser_en; bit counter cleared, data_len and par_en/par_type latched.
REQ-019 Latched length SHALL clamp: <5 -> 5, >MAX_WIDTH -> MAX_WIDTH.
REQ-020 DATA: each sampled strobe shifts one bit into internal shift register and increments counter; no shift without sampled.
REQ-021 DATA -> PARITY after len-th strobe if latched par_en, else -> STOP.
REQ-022 PARITY: on sampled, compare bit with XOR of data bits (even) or its inverse (odd); -> STOP.
REQ-023 STOP: on sampled, bit 1 -> P_Data loaded next edge, data_valid pulses same edge; bit 0 -> frame_err pulses, P_Data unchanged; -> IDLE.
REQ-024 Parity mismatch SHALL pulse par_err in STOP-exit cycle, suppress data_valid, leave P_Data unchanged; if stop also 0, both errors pulse.
REQ-025 P_Data[len-1:0] = received bits in order per LSB_FIRST; P_Data[MAX_WIDTH-1:len] = 0.
REQ-026 frame_start outside IDLE SHALL be ignored.
REQ-027 deser_en low in any state -> IDLE next edge, no output pulse, P_Data held.
REQ-028 Strobe latency: data_valid/err pulses exactly one CLK after the stop-bit sampled cycle.
REQ-029 Back-to-back frames: frame_start in cycle IDLE is re-entered SHALL be accepted.

Reset
REQ-030 Reset low: state IDLE, counter 0, shift register 0, P_Data 0, data_valid/par_err/frame_err/busy 0, asynchronously.
REQ-031 Reset mid-frame discards partial frame; no pulse on release.

Configuration
REQ-032 Macro RX_DESER_PARITY_EN defined: PARITY state and par_err logic compiled in per REQ-021..024.
REQ-033 Macro undefined: PARITY state absent, DATA -> STOP always, par_en/par_type ignored, par_err tied 0; ports retained.

Verification
REQ-034 MAX_WIDTH=9, LSB_FIRST=1, len=8, par_en=0, bits 1,0,1,1,0,0,1,0 stop 1 -> P_Data=0x04D, one data_valid pulse.
REQ-035 LSB_FIRST=0, len=5, bits 1,0,0,1,1 stop 1 -> P_Data=0x013, upper bits 0.
REQ-036 Macro on, len=8, par_en=1, par_type=0, data 0x03, parity bit 1 -> par_err pulse, no data_valid, P_Data unchanged.
REQ-037 len=8, valid data, stop bit 0 -> frame_err pulse, P_Data unchanged, busy falls next cycle.
REQ-038 deser_en dropped after 3 data bits, then full frame 0xA5 -> first discarded with no pulses, second yields P_Data=0x0A5.
REQ-039 data_len=3 and data_len=15 with MAX_WIDTH=9 -> 5 and 9 bits consumed respectively before STOP.

Source files
------------

// File: rtl/rx_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_deserializer
// Description : Serial-to-parallel frame receiver. Collects a variable number
//               of strobed data bits, an optional parity bit and a stop bit,
//               then presents the right-justified word on P_Data with a
//               one-cycle status pulse.
//               Optional feature macro: RX_DESER_PARITY_EN (parity checking).
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_deserializer #(
    parameter int MAX_WIDTH = 9,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic                           sampled_data,
    input  logic                           sampled,
    input  logic                           deser_en,
    input  logic                           frame_start,
    input  logic [$clog2(MAX_WIDTH+1)-1:0] data_len,
    input  logic                           par_en,
    input  logic                           par_type,
    output logic [MAX_WIDTH-1:0]           P_Data,
    output logic                           data_valid,
    output logic                           par_err,
    output logic                           frame_err,
    output logic                           busy
);

    localparam int LW = $clog2(MAX_WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [LW-1:0]        cnt;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        len_clamped;
    logic [LW-1:0]        wr_idx;
    logic                 last_bit;
    logic [MAX_WIDTH-1:0] shreg;
    logic                 par_bad;
    logic                 par_en_q;

    // Clamp the requested length into the supported 5..MAX_WIDTH range
    always_comb begin
        len_clamped = data_len;
        if (data_len < LW'(5)) begin
            len_clamped = LW'(5);
        end else if (data_len > LW'(MAX_WIDTH)) begin
            len_clamped = LW'(MAX_WIDTH);
        end
    end

    // Bit position of the incoming bit and end-of-data detection
    always_comb begin
        wr_idx   = LSB_FIRST ? cnt : (len_q - LW'(1) - cnt);
        last_bit = (cnt == (len_q - LW'(1)));
    end

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; dropping deser_en always returns to IDLE
    always_comb begin
        state_nxt = state;
        if (!deser_en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (frame_start) state_nxt = S_DATA;
`ifdef RX_DESER_PARITY_EN
                S_DATA:   if (sampled && last_bit) state_nxt = par_en_q ? S_PARITY : S_STOP;
                S_PARITY: if (sampled) state_nxt = S_STOP;
`else
                S_DATA:   if (sampled && last_bit) state_nxt = S_STOP;
`endif
                S_STOP:   if (sampled) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // State-derived outputs
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Data path: bit collection, word publication and stop-bit status pulses
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt        <= '0;
            len_q      <= LW'(5);
            shreg      <= '0;
            P_Data     <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (deser_en) begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            cnt   <= '0;
                            shreg <= '0;
                            len_q <= len_clamped;
                        end
                    end
                    S_DATA: begin
                        if (sampled) begin
                            for (int i = 0; i < MAX_WIDTH; i++) begin
                                if (wr_idx == LW'(i)) begin
                                    shreg[i] <= sampled_data;
                                end
                            end
                            cnt <= cnt + LW'(1);
                        end
                    end
                    S_STOP: begin
                        if (sampled) begin
                            if (sampled_data && !par_bad) begin
                                P_Data     <= shreg;
                                data_valid <= 1'b1;
                            end
                            frame_err <= ~sampled_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RX_DESER_PARITY_EN
    logic par_type_q;
    logic par_acc;

    // Parity tracking: running XOR of data bits, checked against the parity bit
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            par_err <= 1'b0;
            if (deser_en) begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            par_en_q   <= par_en;
                            par_type_q <= par_type;
                            par_acc    <= 1'b0;
                            par_bad    <= 1'b0;
                        end
                    end
                    S_DATA:   if (sampled) par_acc <= par_acc ^ sampled_data;
                    S_PARITY: if (sampled) par_bad <= (sampled_data != (par_acc ^ par_type_q));
                    S_STOP:   if (sampled) par_err <= par_bad;
                    default: ;
                endcase
            end
        end
    end
`else
    logic unused_par;
    assign unused_par = ^{par_en, par_type, par_en_q};
    assign par_en_q   = 1'b0;
    assign par_bad    = 1'b0;
    assign par_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_deserializer
// Description : Self-checking bench for rx_frame_deserializer. Two instances
//               (LSB-first and MSB-first) share the same serial stimulus and
//               are compared against a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_deserializer;

    localparam int MW = 9;
    localparam int LW = $clog2(MW + 1);
`ifdef RX_DESER_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          sampled_data = 1'b0;
    logic          sampled = 1'b0;
    logic          deser_en = 1'b0;
    logic          frame_start = 1'b0;
    logic [LW-1:0] data_len = '0;
    logic          par_en = 1'b0;
    logic          par_type = 1'b0;

    logic [MW-1:0] pd_l, pd_m;
    logic          dv_l, pe_l, fe_l, bz_l;
    logic          dv_m, pe_m, fe_m, bz_m;

    rx_frame_deserializer #(.MAX_WIDTH(MW), .LSB_FIRST(1'b1)) dut_l (
        .CLK(CLK), .Reset(Reset), .sampled_data(sampled_data), .sampled(sampled),
        .deser_en(deser_en), .frame_start(frame_start), .data_len(data_len),
        .par_en(par_en), .par_type(par_type), .P_Data(pd_l), .data_valid(dv_l),
        .par_err(pe_l), .frame_err(fe_l), .busy(bz_l)
    );

    rx_frame_deserializer #(.MAX_WIDTH(MW), .LSB_FIRST(1'b0)) dut_m (
        .CLK(CLK), .Reset(Reset), .sampled_data(sampled_data), .sampled(sampled),
        .deser_en(deser_en), .frame_start(frame_start), .data_len(data_len),
        .par_en(par_en), .par_type(par_type), .P_Data(pd_m), .data_valid(dv_m),
        .par_err(pe_m), .frame_err(fe_m), .busy(bz_m)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int dv_cnt_l = 0, dv_cnt_m = 0, pe_cnt = 0, fe_cnt = 0;
    int exp_dv = 0, exp_pe = 0, exp_fe = 0;
    logic [MW-1:0] exp_l = '0, exp_m = '0;

    // Pulse counters sampled away from the active edge
    always @(negedge CLK) begin
        if (dv_l) dv_cnt_l++;
        if (dv_m) dv_cnt_m++;
        if (pe_l || pe_m) pe_cnt++;
        if (fe_l || fe_m) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Idle gap with junk on the data line, then one strobed bit
    task automatic strobe(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            sampled      = 1'b0;
            sampled_data = 1'($urandom);
            tick();
        end
        sampled      = 1'b1;
        sampled_data = b;
        tick();
        sampled      = 1'b0;
    endtask

    // One complete frame; bits[i] is the i-th bit on the wire
    task automatic run_frame(input string tag, input int dlen, input logic [15:0] bits,
                             input logic pen, input logic ptype, input logic pbit,
                             input logic sbit, input bit poke_start);
        int clen;
        logic [MW-1:0] wl, wm;
        logic x, perr, good;
        clen = (dlen < 5) ? 5 : ((dlen > MW) ? MW : dlen);
        wl = '0; wm = '0; x = 1'b0;
        for (int i = 0; i < clen; i++) begin
            wl[i]          = bits[i];
            wm[clen-1-i]   = bits[i];
            x              = x ^ bits[i];
        end
        perr = PAR_ON && pen && (pbit != (x ^ ptype));
        good = sbit && !perr;

        deser_en    = 1'b1;
        frame_start = 1'b1;
        data_len    = dlen[LW-1:0];
        par_en      = pen;
        par_type    = ptype;
        tick();
        frame_start = 1'b0;
        check({tag, ":busy_start"}, {31'd0, bz_l}, 32'd1);
        for (int i = 0; i < clen; i++) begin
            if (poke_start && i == 2) frame_start = 1'b1;
            strobe(bits[i], $urandom_range(0, 2));
            frame_start = 1'b0;
        end
        check({tag, ":busy_pre_stop"}, {31'd0, bz_l & bz_m}, 32'd1);
        if (PAR_ON && pen) strobe(pbit, $urandom_range(0, 2));
        strobe(sbit, $urandom_range(0, 2));

        if (good) begin
            exp_l = wl;
            exp_m = wm;
            exp_dv++;
        end
        if (perr) exp_pe++;
        if (!sbit) exp_fe++;
        check({tag, ":dv_l"}, {31'd0, dv_l}, {31'd0, good});
        check({tag, ":dv_m"}, {31'd0, dv_m}, {31'd0, good});
        check({tag, ":par_err"}, {31'd0, pe_l}, {31'd0, perr});
        check({tag, ":frame_err"}, {31'd0, fe_l}, {31'd0, ~sbit});
        check({tag, ":pdata_l"}, {23'd0, pd_l}, {23'd0, exp_l});
        check({tag, ":pdata_m"}, {23'd0, pd_m}, {23'd0, exp_m});
        check({tag, ":busy_end"}, {31'd0, bz_l}, 32'd0);
    endtask

    initial begin
        logic [15:0] rb;
        #2 Reset = 1'b0;
        tick();
        tick();
        check("rst:pdata_l", {23'd0, pd_l}, 32'd0);
        check("rst:pdata_m", {23'd0, pd_m}, 32'd0);
        check("rst:flags", {28'd0, dv_l, pe_l, fe_l, bz_l}, 32'd0);
        Reset = 1'b1;
        tick();

        // LSB-first 8-bit frame, no parity
        run_frame("lsb8", 8, 16'h004D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lsb8:value", {23'd0, pd_l}, 32'h04D);
        // 5-bit frame, MSB-first instance
        run_frame("msb5", 5, 16'h0019, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("msb5:value", {23'd0, pd_m}, 32'h013);
        // Even parity with a wrong parity bit
        run_frame("parbad", 8, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // Odd parity with a correct parity bit
        run_frame("parok", 8, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        // Bad stop bit
        run_frame("stop0", 8, 16'h00C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Spurious frame_start mid-frame must be ignored
        run_frame("poke", 9, 16'h0155, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Abort after 3 data bits, then a full frame
        deser_en    = 1'b1;
        frame_start = 1'b1;
        data_len    = LW'(8);
        par_en      = 1'b0;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) strobe(1'b1, 1);
        deser_en = 1'b0;
        tick();
        check("abort:busy", {31'd0, bz_l | bz_m}, 32'd0);
        deser_en = 1'b1;
        sampled  = 1'b1;
        tick();
        sampled  = 1'b0;
        check("abort:no_pulse", {29'd0, dv_l, pe_l, fe_l}, 32'd0);
        check("abort:pdata", {23'd0, pd_l}, {23'd0, exp_l});
        run_frame("after_abort", 8, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("after_abort:value", {23'd0, pd_l}, 32'h0A5);

        // Length clamping
        run_frame("len3", 3, 16'h001E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("len15", 15, 16'h7FAB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            rb = 16'($urandom);
            run_frame("rand", $urandom_range(3, 15), rb, 1'($urandom), 1'($urandom),
                      1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
        end

        // Asynchronous reset mid-frame
        deser_en    = 1'b1;
        frame_start = 1'b1;
        data_len    = LW'(8);
        tick();
        frame_start = 1'b0;
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        #2 Reset = 1'b0;
        #1;
        exp_l = '0;
        exp_m = '0;
        check("midrst:busy", {31'd0, bz_l | bz_m}, 32'd0);
        check("midrst:pdata", {23'd0, pd_l | pd_m}, 32'd0);
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) strobe(1'b1, 0);
        check("midrst:idle", {28'd0, dv_l, pe_l, fe_l, bz_l}, 32'd0);
        run_frame("post_rst", 7, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();

        check("total:dv_l", dv_cnt_l, exp_dv);
        check("total:dv_m", dv_cnt_m, exp_dv);
        check("total:par_err", pe_cnt, exp_pe);
        check("total:frame_err", fe_cnt, exp_fe);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
